// File: rtl/io_cfg_pkg.sv
// Shared types and constants for the I/O pad configuration loader.
// A pad config word is {TSMUX[1:0], DORREG}.
package io_cfg_pkg;

    localparam int unsigned CFG_BITS   = 3;
    localparam int unsigned TSMUX_HI   = 2;
    localparam int unsigned TSMUX_LO   = 1;
    localparam int unsigned DORREG_BIT = 0;

    localparam logic [1:0] TSMUX_HIZ       = 2'b00;
    localparam logic [1:0] TSMUX_TSCTL     = 2'b01;
    localparam logic [1:0] TSMUX_DRIVE     = 2'b10;
    localparam logic [1:0] TSMUX_DRIVE_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Assemble a pad config word from its fields.
    function automatic logic [CFG_BITS-1:0] pack_cfg(input logic [1:0] tsmux, input logic dorreg);
        logic [CFG_BITS-1:0] v;
        v             = '0;
        v[TSMUX_HI]   = tsmux[1];
        v[TSMUX_LO]   = tsmux[0];
        v[DORREG_BIT] = dorreg;
        return v;
    endfunction

endpackage

// File: rtl/io_cfg_shifter.sv
// Serialiser: walks the shadow image from pad NUM_IO-1 bit2 down to pad 0 bit0,
// presenting one registered bit per cycle on o_sdo.
module io_cfg_shifter
    import io_cfg_pkg::*;
#(
    parameter int unsigned NUM_IO = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_advance,
    input  logic [CFG_BITS-1:0] i_image [NUM_IO],
    output logic                o_sdo,
    output logic                o_last_c
);

    localparam int unsigned TOT_BITS = NUM_IO * CFG_BITS;
    localparam int unsigned CNT_W    = $clog2(TOT_BITS);
    localparam int unsigned PAD_W    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int unsigned BIT_W    = $clog2(CFG_BITS);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PAD_W-1:0] r_pad, w_pad_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic             r_sdo, w_sdo_nxt;

    // Next bit index and the data bit it selects; SDO falls to 0 outside a shift.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_pad_nxt = r_pad;
        w_bit_nxt = r_bit;
        w_sdo_nxt = 1'b0;
        if (i_start) begin
            w_cnt_nxt = '0;
            w_pad_nxt = PAD_W'(NUM_IO - 1);
            w_bit_nxt = BIT_W'(TSMUX_HI);
            w_sdo_nxt = i_image[w_pad_nxt][w_bit_nxt];
        end else if (i_advance) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_bit == BIT_W'(DORREG_BIT)) begin
                w_pad_nxt = r_pad - PAD_W'(1);
                w_bit_nxt = BIT_W'(TSMUX_HI);
            end else begin
                w_bit_nxt = r_bit - BIT_W'(1);
            end
            w_sdo_nxt = i_image[w_pad_nxt][w_bit_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_pad <= '0;
            r_bit <= '0;
            r_sdo <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pad <= w_pad_nxt;
            r_bit <= w_bit_nxt;
            r_sdo <= w_sdo_nxt;
        end
    end

    assign o_sdo    = r_sdo;
    assign o_last_c = (r_cnt == CNT_W'(TOT_BITS - 1));

endmodule

// File: rtl/io_cfg_loader.sv
// Pad configuration loader: host-written shadow file, serial shift into the pad
// chain on COMMIT, then a single latch strobe and DONE pulse.
module io_cfg_loader
    import io_cfg_pkg::*;
#(
    parameter int unsigned NUM_IO = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                IOCLK,
    input  logic                RST_N,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    input  logic [ADDR_W-1:0]   CFG_ADDR,
    input  logic [CFG_BITS-1:0] CFG_DATA,
    output logic                CFG_ERR,
    input  logic                COMMIT,
    output logic                BUSY,
    output logic                SDO,
    output logic                SHIFT_EN,
    output logic                CFG_LATCH,
    output logic                DONE
);

    localparam int unsigned   PAD_W     = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [ADDR_W:0] NUM_IO_A = (ADDR_W + 1)'(NUM_IO);

    state_e              r_state, w_state_nxt;
    logic [CFG_BITS-1:0] r_shadow     [NUM_IO];
    logic [CFG_BITS-1:0] w_shadow_nxt [NUM_IO];
    logic                r_pending, w_pending_nxt;
    logic                r_ready, r_err, r_busy, r_shift_en, r_latch, r_done;
    logic                w_ready_nxt, w_err_nxt, w_busy_nxt, w_shift_en_nxt, w_latch_nxt, w_done_nxt;
    logic                w_wr_acc, w_addr_ok, w_start, w_advance, w_last;

    assign w_wr_acc  = CFG_VALID && r_ready;
    assign w_addr_ok = ({1'b0, CFG_ADDR} < NUM_IO_A);

    // Post-write image; the shifter reads this so a write coinciding with COMMIT is shifted.
    always_comb begin
        for (int i = 0; i < NUM_IO; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
        end
        if (w_wr_acc && w_addr_ok) begin
            w_shadow_nxt[PAD_W'(CFG_ADDR)] = CFG_DATA;
        end
    end

    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_IO; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IO; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
            end
        end
    end

    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending or coincident commit in DONE restarts the shift with no IDLE gap.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (COMMIT) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (r_pending || COMMIT) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_advance = (r_state == ST_SHIFT) && !w_last;

    always_comb begin
        w_pending_nxt  = r_pending;
        w_ready_nxt    = (w_state_nxt == ST_IDLE);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_shift_en_nxt = (w_state_nxt == ST_SHIFT);
        w_latch_nxt    = (w_state_nxt == ST_LATCH);
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_err_nxt      = w_wr_acc && !w_addr_ok;
        if (w_start) begin
            w_pending_nxt = 1'b0;
        end else if (COMMIT && (r_state != ST_IDLE)) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending  <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_shift_en <= 1'b0;
            r_latch    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_shift_en <= w_shift_en_nxt;
            r_latch    <= w_latch_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    io_cfg_shifter #(
        .NUM_IO (NUM_IO)
    ) u_shifter (
        .clk       (IOCLK),
        .rst_n     (RST_N),
        .i_start   (w_start),
        .i_advance (w_advance),
        .i_image   (w_shadow_nxt),
        .o_sdo     (SDO),
        .o_last_c  (w_last)
    );

    assign CFG_READY = r_ready;
    assign CFG_ERR   = r_err;
    assign BUSY      = r_busy;
    assign SHIFT_EN  = r_shift_en;
    assign CFG_LATCH = r_latch;
    assign DONE      = r_done;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Scoreboard bench for io_cfg_loader: stimulus queues the expected serial
// stream, a negedge monitor pops and compares each shifted bit.
module tb_io_cfg_loader;
    import io_cfg_pkg::*;

    localparam int unsigned NUM_IO = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int          TOT    = 24;

    logic              IOCLK     = 1'b0;
    logic              RST_N     = 1'b0;
    logic              CFG_VALID = 1'b0;
    logic [ADDR_W-1:0] CFG_ADDR  = '0;
    logic [2:0]        CFG_DATA  = '0;
    logic              COMMIT    = 1'b0;
    logic              CFG_READY, CFG_ERR, BUSY, SDO, SHIFT_EN, CFG_LATCH, DONE;

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   q_sdo[$];
    logic [2:0] model [NUM_IO];
    int   run_len   = 0;
    int   latch_cnt = 0;
    bit   prev_latch = 1'b0;

    io_cfg_loader #(.NUM_IO(NUM_IO), .ADDR_W(ADDR_W)) dut (
        .IOCLK(IOCLK), .RST_N(RST_N), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_ERR(CFG_ERR), .COMMIT(COMMIT),
        .BUSY(BUSY), .SDO(SDO), .SHIFT_EN(SHIFT_EN), .CFG_LATCH(CFG_LATCH), .DONE(DONE)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every shifted bit must match the head of the expected stream.
    always @(negedge IOCLK) begin
        if (!RST_N) begin
            run_len    = 0;
            prev_latch = 1'b0;
        end else begin
            if (SHIFT_EN) begin
                run_len++;
                if (q_sdo.size() == 0) begin
                    check("sdo_unexpected", 32'(1), 32'(0));
                end else begin
                    check("sdo", 32'(SDO), 32'(q_sdo.pop_front()));
                end
            end else begin
                check("sdo_idle_zero", 32'(SDO), 32'(0));
            end
            if (CFG_LATCH) begin
                check("latch_run_len", 32'(run_len), 32'(TOT));
                run_len = 0;
                latch_cnt++;
            end
            if (DONE) begin
                check("done_after_latch", 32'(prev_latch), 32'(1));
            end
            prev_latch = CFG_LATCH;
        end
    end

    task automatic push_image();
        for (int p = NUM_IO - 1; p >= 0; p--) begin
            for (int b = 2; b >= 0; b--) begin
                q_sdo.push_back(model[p][b]);
            end
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NUM_IO; p++) model[p] = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge IOCLK);
        #2 RST_N = 1'b0;
        clear_model();
        q_sdo.delete();
        #1 check("reset_outputs", 32'({SDO, SHIFT_EN, CFG_LATCH, DONE, CFG_ERR, BUSY, CFG_READY}), 32'(7'b0000001));
        repeat (2) @(negedge IOCLK);
        RST_N = 1'b1;
        @(negedge IOCLK);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic write(input int addr, input logic [2:0] data);
        int budget = 100;
        CFG_VALID = 1'b1;
        CFG_ADDR  = ADDR_W'(addr);
        CFG_DATA  = data;
        while (!CFG_READY && budget > 0) begin
            @(negedge IOCLK);
            budget--;
        end
        if (!CFG_READY) check("write_ready_timeout", 32'(0), 32'(1));
        @(negedge IOCLK);
        CFG_VALID = 1'b0;
        if (addr < int'(NUM_IO)) model[addr] = data;
        check("cfg_err", 32'(CFG_ERR), 32'(addr >= int'(NUM_IO)));
    endtask

    task automatic commit();
        push_image();
        COMMIT = 1'b1;
        @(negedge IOCLK);
        COMMIT = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 200;
        while (!DONE && budget > 0) begin
            @(negedge IOCLK);
            budget--;
        end
        check("done_seen", 32'(DONE), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int latch_before;
        clear_model();

        // Power-on reset.
        repeat (2) @(negedge IOCLK);
        check("por_outputs", 32'({SDO, SHIFT_EN, CFG_LATCH, DONE, CFG_ERR, BUSY, CFG_READY}), 32'(7'b0000001));
        RST_N = 1'b1;
        @(negedge IOCLK);

        // Empty image: exact cycle timing of SHIFT_EN/LATCH/DONE/BUSY.
        commit();
        for (int k = 1; k <= 27; k++) begin
            if (k > 1) @(negedge IOCLK);
            check($sformatf("timing_k%0d", k),
                  32'({SHIFT_EN, CFG_LATCH, DONE, BUSY}),
                  32'({k <= TOT, k == TOT + 1, k == TOT + 2, k <= TOT + 2}));
        end
        check("ready_after_done", 32'(CFG_READY), 32'(1));

        // pad7=101, pad0=011: stream begins 1,0,1 and ends 0,1,1.
        write(7, pack_cfg(TSMUX_DRIVE, 1'b1));
        write(0, pack_cfg(TSMUX_TSCTL, 1'b1));
        commit();
        wait_done();
        @(negedge IOCLK);

        // Out-of-range address is dropped and flagged.
        do_reset();
        write(8, pack_cfg(TSMUX_DRIVE_ALT, 1'b1));
        @(negedge IOCLK);
        check("err_one_cycle", 32'(CFG_ERR), 32'(0));
        commit();
        wait_done();
        @(negedge IOCLK);

        // Commit mid-shift becomes pending; host write held off until idle.
        do_reset();
        write(1, pack_cfg(TSMUX_HIZ, 1'b1));
        write(6, pack_cfg(TSMUX_DRIVE_ALT, 1'b0));
        commit();
        repeat (9) @(negedge IOCLK);
        push_image();
        COMMIT    = 1'b1;
        CFG_VALID = 1'b1;
        CFG_ADDR  = ADDR_W'(2);
        CFG_DATA  = pack_cfg(TSMUX_DRIVE, 1'b0);
        @(negedge IOCLK);
        COMMIT = 1'b0;
        check("ready_low_in_shift", 32'(CFG_READY), 32'(0));
        wait_done();
        @(negedge IOCLK);
        check("reshift_no_idle", 32'({SHIFT_EN, CFG_READY}), 32'(2'b10));
        wait_done();
        @(negedge IOCLK);
        check("ready_after_second_done", 32'(CFG_READY), 32'(1));
        model[2] = pack_cfg(TSMUX_DRIVE, 1'b0);
        @(negedge IOCLK);
        CFG_VALID = 1'b0;
        commit();
        wait_done();
        @(negedge IOCLK);

        // Write and commit on the same edge: pad3=010 lands in stream bits 12..14.
        do_reset();
        CFG_VALID = 1'b1;
        CFG_ADDR  = ADDR_W'(3);
        CFG_DATA  = pack_cfg(TSMUX_TSCTL, 1'b0);
        model[3]  = pack_cfg(TSMUX_TSCTL, 1'b0);
        commit();
        CFG_VALID = 1'b0;
        wait_done();
        @(negedge IOCLK);

        // Reset during shift cycle 5 aborts with no latch and clears the shadow file.
        do_reset();
        write(6, pack_cfg(TSMUX_DRIVE_ALT, 1'b1));
        commit();
        repeat (3) @(negedge IOCLK);
        check("sdo_before_abort", 32'({SHIFT_EN, SDO}), 32'(2'b11));
        @(negedge IOCLK);
        latch_before = latch_cnt;
        #2 RST_N = 1'b0;
        q_sdo.delete();
        clear_model();
        #1 check("abort_outputs", 32'({SHIFT_EN, SDO, BUSY, CFG_READY}), 32'(4'b0001));
        repeat (2) @(negedge IOCLK);
        RST_N = 1'b1;
        repeat (30) @(negedge IOCLK);
        check("no_latch_after_abort", 32'(latch_cnt - latch_before), 32'(0));
        check("ready_after_abort", 32'({CFG_READY, DONE}), 32'(2'b10));
        commit();
        wait_done();
        @(negedge IOCLK);

        check("sdo_queue_empty", 32'(q_sdo.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
